// File: rtl/cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cmd_sequencer
// Description : Start/abort controlled sequencer. After an accepted start it
//               counts up in ADD1 (saturating, STEP per cycle) until the
//               latched limit is reached, holds in ADD2 for HOLD_CYC cycles,
//               then pulses oDone for one cycle. A watchdog ends ADD1 after
//               TIMEOUT_CYC cycles. Sticky status flags report timeout,
//               abort and passage through reset.
// Ports       : iClock       clock, rising edge
//               Reset        synchronous active-high reset
//               iStart       start request (sampled in IDLE only)
//               iLimit       count limit, latched on accepted start
//               iAbort       abort request (effective in ADD1/ADD2)
//               oCount       running count
//               oBusy        high while in ADD1 or ADD2
//               oDone        high for the single DONE cycle
//               oTimeout     sticky watchdog flag
//               oAborted     sticky abort flag
//               oPassedReset sticky "came through reset" flag
//               oState       encoded state (RESET=0 IDLE=1 ADD1=2 ADD2=3 DONE=4)
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_sequencer #(
    parameter int DATA_W      = 32,
    parameter int STEP        = 1,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              iClock,
    input  logic              Reset,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iLimit,
    input  logic              iAbort,
    output logic [DATA_W-1:0] oCount,
    output logic              oBusy,
    output logic              oDone,
    output logic              oTimeout,
    output logic              oAborted,
    output logic              oPassedReset,
    output logic [2:0]        oState
);

    localparam logic [2:0] c_S_RESET = 3'd0;
    localparam logic [2:0] c_S_IDLE  = 3'd1;
    localparam logic [2:0] c_S_ADD1  = 3'd2;
    localparam logic [2:0] c_S_ADD2  = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    localparam logic [DATA_W:0]    c_STEP      = (DATA_W+1)'(STEP);
    localparam logic [TIMEOUT_W-1:0] c_TO_LAST   = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] c_HOLD_LAST = TIMEOUT_W'(HOLD_CYC - 1);

    logic [2:0]           r_state,   w_state;
    logic [TIMEOUT_W-1:0] r_timer,   w_timer;
    logic [DATA_W-1:0]    r_limit,   w_limit;
    logic [DATA_W-1:0]    r_count,   w_count;
    logic                 r_busy,    w_busy;
    logic                 r_done,    w_done;
    logic                 r_timeout, w_timeout;
    logic                 r_aborted, w_aborted;
    logic                 r_passed,  w_passed;

    // One extra bit catches the carry so the count clamps at all-ones
    // instead of wrapping.
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_sat;
    logic              w_reached;

    assign w_sum     = {1'b0, r_count} + c_STEP;
    assign w_sat     = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
    assign w_reached = (r_count >= r_limit);

    always_comb begin
        w_state   = r_state;
        w_timer   = r_timer;
        w_limit   = r_limit;
        w_count   = r_count;
        w_timeout = r_timeout;
        w_aborted = r_aborted;
        w_passed  = r_passed;

        case (r_state)
            c_S_RESET: begin
                w_state = c_S_IDLE;
            end
            c_S_IDLE: begin
                if (iStart) begin
                    w_limit   = iLimit;
                    w_count   = '0;
                    w_timeout = 1'b0;
                    w_aborted = 1'b0;
                    w_passed  = 1'b0;
                    w_state   = c_S_ADD1;
                end
            end
            c_S_ADD1: begin
                if (iAbort) begin
                    w_state   = c_S_IDLE;
                    w_aborted = 1'b1;
                end else if (w_reached) begin
                    w_state = c_S_ADD2;
                end else begin
                    // The last watchdog cycle still counts; the value then
                    // freezes in IDLE.
                    w_count = w_sat;
                    w_timer = r_timer + 1'b1;
                    if (r_timer == c_TO_LAST) begin
                        w_state   = c_S_IDLE;
                        w_timeout = 1'b1;
                    end
                end
            end
            c_S_ADD2: begin
                if (iAbort) begin
                    w_state   = c_S_IDLE;
                    w_aborted = 1'b1;
                end else if (r_timer == c_HOLD_LAST) begin
                    w_state = c_S_DONE;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            c_S_DONE: begin
                w_state = c_S_IDLE;
            end
            default: begin
                w_state = c_S_IDLE;
            end
        endcase

        // Every state is timed from zero.
        if (w_state != r_state) begin
            w_timer = '0;
        end

        // Status outputs are decoded from the next state so they line up
        // with oState while still coming straight from flops.
        w_busy = (w_state == c_S_ADD1) || (w_state == c_S_ADD2);
        w_done = (w_state == c_S_DONE);
    end

    always_ff @(posedge iClock) begin
        if (Reset) begin
            r_state   <= c_S_RESET;
            r_timer   <= '0;
            r_limit   <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_aborted <= 1'b0;
            r_passed  <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_timer   <= w_timer;
            r_limit   <= w_limit;
            r_count   <= w_count;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_timeout <= w_timeout;
            r_aborted <= w_aborted;
            r_passed  <= w_passed;
        end
    end

    assign oCount       = r_count;
    assign oBusy        = r_busy;
    assign oDone        = r_done;
    assign oTimeout     = r_timeout;
    assign oAborted     = r_aborted;
    assign oPassedReset = r_passed;
    assign oState       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_sequencer
// Description : Self-checking bench for cmd_sequencer. Instance A (32-bit,
//               STEP=1, HOLD=2, watchdog 16) runs directed and random
//               operations whose outcomes are predicted per operation and
//               checked by an independent monitor. Instances B and C (8-bit,
//               STEP=3 and STEP=100) exercise the count sequence and
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_sequencer;

    localparam longint c_A_STEP = 1;
    localparam int     c_A_HOLD = 2;
    localparam int     c_A_TO   = 16;
    localparam longint c_A_MAX  = 64'hFFFF_FFFF;

    logic iClock = 1'b0;
    always #5 iClock = ~iClock;

    logic        Reset = 1'b1;
    logic        a_start = 1'b0, a_abort = 1'b0;
    logic [31:0] a_limit = '0;
    logic [31:0] a_count;
    logic        a_busy, a_done, a_timeout, a_aborted, a_passed;
    logic [2:0]  a_state;

    logic        bc_start = 1'b0, bc_abort = 1'b0;
    logic [7:0]  b_limit = '0, c_limit = '0;
    logic [7:0]  b_count, c_count;
    logic        b_busy, b_done, b_timeout, b_aborted, b_passed;
    logic        c_busy, c_done, c_timeout, c_aborted, c_passed;
    logic [2:0]  b_state, c_state;

    cmd_sequencer #(.DATA_W(32), .STEP(1), .HOLD_CYC(c_A_HOLD), .TIMEOUT_W(16), .TIMEOUT_CYC(c_A_TO)) u_a (
        .iClock(iClock), .Reset(Reset), .iStart(a_start), .iLimit(a_limit), .iAbort(a_abort),
        .oCount(a_count), .oBusy(a_busy), .oDone(a_done), .oTimeout(a_timeout),
        .oAborted(a_aborted), .oPassedReset(a_passed), .oState(a_state));

    cmd_sequencer #(.DATA_W(8), .STEP(3), .HOLD_CYC(3), .TIMEOUT_W(16), .TIMEOUT_CYC(200)) u_b (
        .iClock(iClock), .Reset(Reset), .iStart(bc_start), .iLimit(b_limit), .iAbort(bc_abort),
        .oCount(b_count), .oBusy(b_busy), .oDone(b_done), .oTimeout(b_timeout),
        .oAborted(b_aborted), .oPassedReset(b_passed), .oState(b_state));

    cmd_sequencer #(.DATA_W(8), .STEP(100), .HOLD_CYC(1), .TIMEOUT_W(16), .TIMEOUT_CYC(200)) u_c (
        .iClock(iClock), .Reset(Reset), .iStart(bc_start), .iLimit(c_limit), .iAbort(bc_abort),
        .oCount(c_count), .oBusy(c_busy), .oDone(c_done), .oTimeout(c_timeout),
        .oAborted(c_aborted), .oPassedReset(c_passed), .oState(c_state));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint clampv(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    // Expected outcome of one operation, measured when oBusy falls.
    typedef struct {
        longint count;
        bit     done;
        bit     tmo;
        bit     abt;
        int     cycles;
    } exp_t;

    exp_t sb[$];

    // Outcome from the rules: ADD1 needs ceil(L/STEP)+1 cycles; if that
    // exceeds the watchdog, the watchdog ends it instead; an abort at busy
    // cycle a ends the operation there with the count seen in that cycle.
    function automatic exp_t model(input longint lim, input int abort_at);
        exp_t   e;
        longint k;
        k = (lim + c_A_STEP - 1) / c_A_STEP;
        e.abt = 1'b0;
        if (k + 1 > c_A_TO) begin
            e.tmo    = 1'b1;
            e.done   = 1'b0;
            e.cycles = c_A_TO;
            e.count  = clampv(c_A_TO * c_A_STEP, c_A_MAX);
        end else begin
            e.tmo    = 1'b0;
            e.done   = 1'b1;
            e.cycles = int'(k) + 1 + c_A_HOLD;
            e.count  = clampv(k * c_A_STEP, c_A_MAX);
        end
        if (abort_at >= 0 && abort_at < e.cycles) begin
            e.abt    = 1'b1;
            e.done   = 1'b0;
            e.tmo    = 1'b0;
            e.cycles = abort_at + 1;
            if (abort_at <= k) e.count = clampv(abort_at * c_A_STEP, c_A_MAX);
        end
        return e;
    endfunction

    // Monitor: samples on the falling edge, independent of the driver.
    bit mon_prev = 1'b0;
    int mon_cnt  = 0;

    always @(negedge iClock) begin
        exp_t e;
        if (Reset) begin
            mon_prev = 1'b0;
            mon_cnt  = 0;
        end else begin
            if (a_busy && !mon_prev) begin
                check("start_state",   a_state,   2);
                check("start_count",   a_count,   0);
                check("start_timeout", a_timeout, 0);
                check("start_aborted", a_aborted, 0);
                check("start_passed",  a_passed,  0);
            end
            if (a_busy) begin
                mon_cnt++;
            end else if (mon_prev) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_end", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("end_count",   a_count,   e.count);
                    check("end_done",    a_done,    e.done);
                    check("end_timeout", a_timeout, e.tmo);
                    check("end_aborted", a_aborted, e.abt);
                    check("end_cycles",  mon_cnt,   e.cycles);
                    check("end_state",   a_state,   e.done ? 4 : 1);
                end
                mon_cnt = 0;
            end
            mon_prev = a_busy;
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    // One operation on instance A; iStart/iLimit are scrambled while busy
    // to show they are ignored.
    task automatic run_op(input longint lim, input int abort_at);
        int j;
        a_limit = lim[31:0];
        a_start = 1'b1;
        sb.push_back(model(lim, abort_at));
        tick();
        a_start = 1'b0;
        j = 0;
        while (a_busy && j < 200) begin
            a_abort = (j == abort_at);
            a_start = ($urandom_range(0, 3) == 0);
            a_limit = $urandom;
            tick();
            j++;
        end
        a_abort = 1'b0;
        a_start = 1'b0;
        if (j >= 200) check("op_cycle_bound", j, 0);
        if (a_state == 3'd4) tick();
        check("op_back_idle", a_state, 1);
    endtask

    initial begin
        int  bk, ck, bdn, cdn, j;
        bit  prev_abt;

        // Reset held for two cycles, then released.
        tick();
        check("rst_state",  a_state,  0);
        check("rst_passed", a_passed, 1);
        tick();
        check("rst_state2", a_state,  0);
        check("rst_count",  a_count,  0);
        check("rst_busy",   a_busy,   0);
        check("rst_done",   a_done,   0);
        Reset = 1'b0;
        tick();
        check("idle_state",  a_state,  1);
        check("idle_passed", a_passed, 1);
        check("idle_count",  a_count,  0);
        check("idle_busy",   a_busy,   0);
        check("b_idle_state", b_state, 1);

        // B: 0,3,...,252,255. C: 0,100,200 then clamps to 255.
        b_limit  = 8'd255;
        c_limit  = 8'd250;
        bc_start = 1'b1;
        tick();
        bc_start = 1'b0;
        bk = 0; ck = 0; bdn = 0; cdn = 0; j = 0;
        while ((b_busy || c_busy || b_done || c_done) && j < 300) begin
            if (b_state == 3'd2) begin
                check("b_seq", b_count, clampv(bk * 3, 255));
                bk++;
            end
            if (c_state == 3'd2) begin
                check("c_seq", c_count, clampv(ck * 100, 255));
                ck++;
            end
            if (b_done) bdn++;
            if (c_done) cdn++;
            tick();
            j++;
        end
        check("bc_bound",   (j < 300) ? 1 : 0, 1);
        check("b_add1_len", bk, 86);
        check("c_add1_len", ck, 4);
        check("b_done_cnt", bdn, 1);
        check("c_done_cnt", cdn, 1);
        check("b_final",    b_count, 255);
        check("c_final",    c_count, 255);
        check("b_flags",    {b_timeout, b_aborted, b_passed}, 0);
        check("c_flags",    {c_timeout, c_aborted, c_passed}, 0);

        // Directed operations on A.
        run_op(4, -1);
        check("hold_count4", a_count, 4);
        check("hold_passed", a_passed, 0);
        run_op(0, -1);
        check("hold_count0", a_count, 0);
        run_op(100, -1);
        check("timeout_sticky", a_timeout, 1);
        run_op(4, 6);
        check("abort_sticky", a_aborted, 1);

        // Abort in IDLE is ignored.
        prev_abt = a_aborted;
        a_abort  = 1'b1;
        tick();
        a_abort  = 1'b0;
        check("idle_abort_state", a_state, 1);
        check("idle_abort_flag",  a_aborted, prev_abt);

        // Reset in the middle of ADD1.
        a_limit = 32'd10;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (3) tick();
        check("mid_add1", a_state, 2);
        Reset = 1'b1;
        tick();
        check("mid_rst_state",  a_state,  0);
        check("mid_rst_count",  a_count,  0);
        check("mid_rst_passed", a_passed, 1);
        check("mid_rst_busy",   a_busy,   0);
        Reset = 1'b0;
        tick();
        check("mid_rst_idle", a_state, 1);
        check("mid_rst_done", a_done,  0);

        // Random operations, some timing out, some aborted.
        for (int n = 0; n < 40; n++) begin
            longint lim;
            int     ab;
            lim = $urandom_range(0, 22);
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 26)) : -1;
            run_op(lim, ab);
        end

        repeat (3) tick();
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
